// File: rtl/iu_pkg.sv
// Shared types and constants for the iu prediction interface.
package iu_pkg;
  localparam int XLEN    = 64;
  localparam int PC_STEP = 4;

  typedef logic [XLEN-1:0] pc_t;

  // Sequential fetch address after pc, as iu's predictor computes it.
  function automatic pc_t pc_next(input pc_t pc);
    return pc + pc_t'(PC_STEP);
  endfunction
endpackage

// File: rtl/iu_pred_checker_if.sv
// Commit-trace and prediction/redirect signals between iu, the commit source and the checker.
interface iu_pred_checker_if;
  import iu_pkg::*;

  logic commit_valid;
  pc_t  commit_pc;
  logic commit_ready;
  pc_t  pc_pre;
  logic pc_pre_oe;
  logic miss;
  pc_t  pc_curr;

  modport master (
    output commit_valid, commit_pc, pc_pre, pc_pre_oe,
    input  commit_ready, miss, pc_curr
  );

  modport slave (
    input  commit_valid, commit_pc, pc_pre, pc_pre_oe,
    output commit_ready, miss, pc_curr
  );
endinterface

// File: rtl/pc_fifo.sv
// DEPTH-entry FIFO of PCs; a push is also taken when full if a pop happens in the same cycle.
module pc_fifo
  import iu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  pc_t                    din,
  output pc_t                    dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  pc_t           r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_pop;
  logic          w_push;

  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign dout   = r_mem[r_rd_ptr];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end
endmodule

// File: rtl/iu_pred_checker.sv
// Scores iu predictions against the oldest committed PC, redirects iu on a miss, keeps statistics.
module iu_pred_checker
  import iu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  iu_pred_checker_if.slave       iu,
  input  logic                   clr_stats,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt,
  output logic [CNT_W-1:0]       nochk_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);
  pc_t              w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_chk;
  logic             w_hit;
  logic             w_mis;
  logic             w_nochk;
  logic             r_miss_p1;
  pc_t              r_pc_curr_p1;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic [CNT_W-1:0] r_nochk_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  pc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (iu.commit_valid),
    .pop   (iu.pc_pre_oe),
    .din   (iu.commit_pc),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  assign iu.commit_ready = !w_full;

  assign w_chk   = iu.pc_pre_oe && !w_empty;
  assign w_hit   = w_chk && (iu.pc_pre == w_head);
  assign w_mis   = w_chk && (iu.pc_pre != w_head);
  assign w_nochk = iu.pc_pre_oe && w_empty;

  // Stage p1: compare result registered at the prediction edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_p1    <= 1'b0;
      r_pc_curr_p1 <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_nochk_cnt  <= '0;
    end else begin
      r_miss_p1 <= w_mis;
      if (w_mis) r_pc_curr_p1 <= w_head;
      if (clr_stats) begin
        r_hit_cnt   <= '0;
        r_miss_cnt  <= '0;
        r_nochk_cnt <= '0;
      end else begin
        if (w_hit)   r_hit_cnt   <= sat_inc(r_hit_cnt);
        if (w_mis)   r_miss_cnt  <= sat_inc(r_miss_cnt);
        if (w_nochk) r_nochk_cnt <= sat_inc(r_nochk_cnt);
      end
    end
  end

  assign iu.miss    = r_miss_p1;
  assign iu.pc_curr = r_pc_curr_p1;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;
  assign nochk_cnt  = r_nochk_cnt;
endmodule

// File: doc/iu_pred_checker.md
Name: iu_pred_checker

Overview:
- Consumer end of the iu prediction interface: accepts committed (architectural) PCs, scores each pc_pre/pc_pre_oe prediction against the oldest committed PC, and drives miss/pc_curr back to the predictor.
- Also keeps hit/miss/unchecked statistics for the sim harness.
- Sits between the commit-trace source and iu in tb-iu.

Parameters:
- DEPTH, 8: commit-PC FIFO entries; power of 2, ≥2.
- CNT_W, 32: width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous reset, active low.
- commit_valid  in  1  a committed PC is presented.
- commit_pc  in  64  committed PC.
- commit_ready  out  1  FIFO can accept; a transfer occurs when valid && ready.
- pc_pre  in  64  prediction from iu; valid only while pc_pre_oe=1.
- pc_pre_oe  in  1  one-cycle prediction strobe from iu.
- miss  out  1  registered; mispredict indication to iu.
- pc_curr  out  64  registered; corrected PC to iu, meaningful while miss=1.
- clr_stats  in  1  synchronous clear of the statistics counters.
- hit_cnt  out  CNT_W  correct predictions.
- miss_cnt  out  CNT_W  mispredictions.
- nochk_cnt  out  CNT_W  predictions arriving with the FIFO empty.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-compare):
  - FIFO empty, fifo_level=0, commit_ready=1.
  - miss=0, pc_curr=0, all counters 0.
  - A pending miss is discarded.
- FIFO:
  - commit_ready = (level != DEPTH).
  - Push on commit_valid && commit_ready. Pop on pc_pre_oe && level!=0.
  - Push and pop in the same cycle are allowed at any level, including full: level unchanged, head advances.
  - Pointers wrap modulo DEPTH.
- Compare, registered at the pc_pre_oe edge (cycle T); outputs visible in T+1:
  - FIFO non-empty, pc_pre == head: hit_cnt++; miss=0 in T+1.
  - FIFO non-empty, pc_pre != head: miss_cnt++; miss=1 and pc_curr=head in T+1. iu samples these in its IDLE cycle and restarts from head, so its next prediction is head+4.
  - FIFO empty: nochk_cnt++; miss=0; no pop.
  - The comparison is a full 64-bit equality.
- miss lasts exactly one cycle; it clears in T+2 unless another pc_pre_oe occurred in T+1.
- pc_curr holds its last value when miss=0.
- Two consecutive pc_pre_oe cycles are each handled independently (no protocol check).
- Counters saturate at all-ones and never wrap.
- clr_stats has priority over any increment in the same cycle and does not affect the FIFO or miss.
- No stall of iu: predictions are never back-pressured.

Decomposition:
- Package iu_pkg:
  - XLEN=64.
  - PC_STEP=4 (shared with iu's predictor).
  - typedef pc_t = logic[XLEN-1:0].
- Sub-module pc_fifo:
  - Generic DEPTH × pc_t synchronous FIFO with push/pop/full/empty/level.
  - Asynchronous active-low reset.
  - Instantiated once; compare logic and counters stay in iu_pred_checker.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, release → miss=0, pc_curr=0, commit_ready=1, fifo_level=0, all counters 0.
- Hit: push 0x1000. Pulse pc_pre_oe with pc_pre=0x1000 → next cycle miss=0, hit_cnt=1, fifo_level=0.
- Miss/redirect: push 0x2000, 0x2004. Pulse pc_pre=0x1004 → next cycle miss=1, pc_curr=0x2000, miss_cnt=1, fifo_level=1; miss=0 one cycle later. Then pc_pre=0x2004 → hit_cnt=1.
- Empty: with no pushes, pulse pc_pre_oe with pc_pre=0x40 → nochk_cnt=1, miss=0, fifo_level stays 0.
- Full: push 8 PCs 0x0..0x1C → commit_ready=0, and a 9th valid is not accepted. In the same cycle, assert pc_pre_oe=0x0 with commit_valid=1, pc=0x20 → pop and push both occur, level stays 8, hit_cnt=1. Drain and check FIFO order 0x4..0x20.
- Reset mid-op and saturation:
  - With CNT_W=4, 16 misses → miss_cnt=0xF (saturated, no wrap).
  - Assert clr_stats alongside a hit → hit_cnt=0.
  - Drop rst_n while miss=1 → miss=0 immediately (asynchronous) and FIFO empty.
